// File: rtl/muldiv_ctrl_pkg.sv
// Shared HI/LO multiply/divide types: operand word, op encodings, controller states.
package muldiv_ctrl_pkg;

  typedef logic [31:0] i32;
  typedef i32          word_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_MUL  = 2'd1,
    MDS_DIV  = 2'd2,
    MDS_DONE = 2'd3
  } muldiv_state_t;

  // Two's-complement magnitude; 0x8000_0000 maps to itself, which the signed divide relies on.
  function automatic word_t mag32(input word_t v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> mul/div controller bundle: operands in, stall/done/HI/LO out.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic       start;
  muldiv_op_t op;
  word_t      a;
  word_t      b;
  logic       flush;
  logic       stall;
  logic       done;
  word_t      hi;
  word_t      lo;

  modport master (output start, op, a, b, flush, input stall, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output stall, done, hi, lo);

endinterface

// File: rtl/muldiv_ctrl_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle for 32 cycles after load.
// quotient/remainder show the result of the step in progress, final when last=1.
module div_seq
  import muldiv_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  kill,
  input  word_t dividend,
  input  word_t divisor,
  output logic  last,
  output word_t quotient,
  output word_t remainder
);

  word_t       rem_q, rem_d;
  word_t       quo_q, quo_d;
  word_t       dvs_q;
  logic [4:0]  cnt_q;
  logic        run_q;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;

  // The shifted partial remainder is below 2*divisor, so it needs 33 bits before the trial subtract.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = ~diff[32];
    rem_d   = fits ? diff[31:0] : shifted[31:0];
    quo_d   = {quo_q[30:0], fits};
  end

  assign last      = run_q && (cnt_q == 5'd31);
  assign quotient  = quo_d;
  assign remainder = rem_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (kill) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO mul/div controller: MULT/MULTU done 2 cycles after start, DIV/DIVU 33, divide-by-zero 1.
// Execute is held by combinational stall until the done pulse; flush abandons the op silently.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input logic         clk,
  input logic         reset,
  muldiv_ctrl_if.slave md
);

  localparam logic [1:0] S_IDLE = MDS_IDLE;
  localparam logic [1:0] S_MUL  = MDS_MUL;
  localparam logic [1:0] S_DIV  = MDS_DIV;
  localparam logic [1:0] S_DONE = MDS_DONE;

  logic [1:0]  state_q, state_d;
  muldiv_op_t  op_q, op_d;
  word_t       a_q, a_d;
  word_t       b_q, b_d;
  word_t       hi_q, hi_d;
  word_t       lo_q, lo_d;

  logic        accept;
  logic        div_load;
  logic        div_last;
  word_t       div_quo;
  word_t       div_rem;
  logic        signed_div;
  word_t       quo_fix;
  word_t       rem_fix;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] prod;

  assign accept   = (state_q == S_IDLE) && md.start && !md.flush;
  assign div_load = accept && md.op[1] && (md.b != '0);

  div_seq u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .kill      (md.flush),
    .dividend  (mag32(md.a, md.op == MD_DIV)),
    .divisor   (mag32(md.b, md.op == MD_DIV)),
    .last      (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};
  assign prod   = (op_q == MD_MULTU) ? prod_u : prod_s;

  assign signed_div = (op_q == MD_DIV);
  assign quo_fix    = (signed_div && (a_q[31] ^ b_q[31])) ? -div_quo : div_quo;
  assign rem_fix    = (signed_div && a_q[31]) ? -div_rem : div_rem;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = md.op;
          a_d  = md.a;
          b_d  = md.b;
          if (!md.op[1]) begin
            state_d = S_MUL;
          end else if (md.b == '0) begin
            hi_d    = md.a;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        hi_d    = prod[63:32];
        lo_d    = prod[31:0];
        state_d = S_DONE;
      end
      S_DIV: begin
        if (div_last) begin
          hi_d    = rem_fix;
          lo_d    = quo_fix;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (md.flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.done  = (state_q == S_DONE);
  assign md.stall = md.start && !md.done && !md.flush;
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, stall length, HI/LO values, flush and reset behaviour.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  muldiv_ctrl_if md_if ();

  muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a clock edge with the controller idle; returns just after the edge that ends done.
  task automatic run_op(input string tag, input muldiv_op_t op, input word_t a, input word_t b,
                        input int exp_lat, input word_t exp_hi, input word_t exp_lo);
    int lat;
    int stall_cyc;
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.a     = a;
    md_if.b     = b;
    #1;
    chk({tag, " stall_at_start"}, 32'(md_if.stall), 32'd1);
    stall_cyc = int'(md_if.stall);
    @(posedge clk); #1;
    lat = 1;
    while (!md_if.done && lat < 100) begin
      stall_cyc += int'(md_if.stall);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " stall_cycles"}, 32'(stall_cyc), 32'(exp_lat));
    chk({tag, " stall_in_done"}, 32'(md_if.stall), 32'd0);
    chk({tag, " hi"}, md_if.hi, exp_hi);
    chk({tag, " lo"}, md_if.lo, exp_lo);
    @(posedge clk); #1;
    md_if.start = 1'b0;
    chk({tag, " done_pulse"}, 32'(md_if.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    reset       = 1'b1;
    md_if.start = 1'b0;
    md_if.flush = 1'b0;
    md_if.op    = MD_MULT;
    md_if.a     = '0;
    md_if.b     = '0;
    #12;
    chk("reset hi", md_if.hi, 32'h0);
    chk("reset lo", md_if.lo, 32'h0);
    chk("reset done", 32'(md_if.done), 32'd0);
    chk("reset stall", 32'(md_if.stall), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFE, 32'd3,         2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("div_m7_2",  MD_DIV,   32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_5_0",  MD_DIVU,  32'd5,         32'd0,         1,  32'd5,         32'hFFFF_FFFF);
    run_op("divu_100_7", MD_DIVU, 32'd100,       32'd7,         33, 32'd2,         32'd14);

    // Flush mid-divide: start accepted at edge N, flush raised in cycle N+10.
    md_if.start = 1'b1;
    md_if.op    = MD_DIV;
    md_if.a     = 32'd1000;
    md_if.b     = 32'd3;
    @(posedge clk); #1;
    seen_done = 0;
    repeat (9) begin
      seen_done += int'(md_if.done);
      @(posedge clk); #1;
    end
    md_if.flush = 1'b1;
    #1;
    chk("flush stall_low", 32'(md_if.stall), 32'd0);
    @(posedge clk); #1;
    md_if.flush = 1'b0;
    seen_done += int'(md_if.done);
    chk("flush no_done", 32'(seen_done), 32'd0);
    chk("flush hi_kept", md_if.hi, 32'd2);
    chk("flush lo_kept", md_if.lo, 32'd14);
    run_op("multu_after_flush", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 2, 32'h0000_0001, 32'hFFFF_FFFE);

    // Reset during a divide: asserted in cycle N+5.
    md_if.start = 1'b1;
    md_if.op    = MD_DIV;
    md_if.a     = 32'd50;
    md_if.b     = 32'd5;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset done", 32'(md_if.done), 32'd0);
    chk("midreset hi", md_if.hi, 32'h0);
    chk("midreset lo", md_if.lo, 32'h0);
    md_if.start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run_op("divu_9_4", MD_DIVU, 32'd9, 32'd4, 33, 32'd1, 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle controller for the HI/LO multiply/divide resource. It sits beside the execute stage. It accepts MULT/MULTU/DIV/DIVU operands from execute and holds the pipeline with a stall request until the 64-bit result is ready. It then pulses `done` with the new HI/LO values for the pipeline to write into its HI/LO registers. Division is a 32-iteration restoring sequence; multiplication is one registered product cycle.

## Interface
- No parameters; width fixed at 32 (`i32` / `word_t`).
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  execute holds a mul/div instruction; held high until `done`
- `op`  in  2  `muldiv_op_t`: MD_MULT=00, MD_MULTU=01, MD_DIV=10, MD_DIVU=11
- `a`  in  32  rs value (dividend / multiplicand)
- `b`  in  32  rt value (divisor / multiplier)
- `flush`  in  1  kill the in-flight operation
- `stall`  out  1  combinational: `start && !done && !flush`
- `done`  out  1  one-cycle pulse; `hi`/`lo` valid in that cycle
- `hi`  out  32  product[63:32] / remainder
- `lo`  out  32  product[31:0] / quotient

## Operation
- States: IDLE, MUL, DIV, DONE.
- **IDLE**
  - When `start && !flush`: latch `op`, `a`, `b`; clear the iteration counter.
  - Next state: MUL for MULT/MULTU; DONE for DIV/DIVU with `b==0`; otherwise DIV.
- **MUL**
  - Compute the 64-bit product (signed for MULT, unsigned for MULTU) into `hi:lo`.
  - Next state: DONE.
- **DIV**
  - Operate on magnitudes: |a|, |b| for DIV; raw values for DIVU.
  - One restoring step per cycle on a 64-bit remainder:quotient shift register, counter 0..31.
  - At counter==31, apply sign fix and load `hi`/`lo`:
    - quotient negated if `a[31]^b[31]`;
    - remainder negated if `a[31]` (DIV only).
  - Next state: DONE.
- **Divide by zero:** no iterations. Load `hi=a`, `lo=32'hFFFF_FFFF` for both DIV and DIVU.
- **DIV 0x8000_0000 / -1:** magnitude arithmetic wraps, giving `lo=0x8000_0000`, `hi=0`.
- **DONE:** `done=1`. Next state: IDLE unconditionally.
- **Flush**
  - `flush` in any state → IDLE next edge.
  - `done` is never asserted for the flushed operation; `hi`/`lo` keep their previous values.
  - Flush and start together: flush wins, nothing is accepted.
- **Start while not IDLE:** ignored; it is the same held instruction.
- **Reset (async, any time):** state=IDLE, counter=0, `done=0`, `hi=0`, `lo=0`, latched operands=0. `stall` follows its combinational equation.

## Timing
- Start sampled in IDLE at edge N.
- **MULT/MULTU:** MUL during N+1, `done` at N+2. `stall` high in N, N+1; low in N+2.
- **DIV/DIVU:** DIV during N+1..N+32, `done` at N+33. `stall` high for 33 cycles.
- **Divide by zero:** `done` at N+1.
- **Back-to-back:** the pipeline advances at the `done` edge. A new `start` is seen in IDLE the cycle after `done` and is accepted there. Minimum spacing between starts is latency+1.
- **Result outputs:** `hi`/`lo` are registered and hold their value until the next completed operation.

## Structure
- Shared pipeline package: `muldiv_op_t` enum and its encodings; `muldiv_state_t` enum.
- Sub-module `div_seq`: unsigned 32-cycle restoring divider.
  - Inputs: `clk`, `reset`, `load`, `kill`, dividend, divisor.
  - Outputs: `last`, quotient, remainder.
- The top level handles op latching, magnitude/sign correction, multiply, the FSM and `stall`.

## Test plan
- MULTU a=0xFFFF_FFFF b=0xFFFF_FFFF → `done` at N+2, hi=0xFFFF_FFFE, lo=0x0000_0001; `stall` high exactly 2 cycles.
- MULT a=0xFFFF_FFFE (-2) b=3 → hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- Divides, each with `done` at N+33 and `stall` 33 cycles:
  - DIV a=-7 b=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
  - DIVU 100/7 → lo=14, hi=2.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIVU 5/0 → `done` at N+1, hi=5, lo=0xFFFF_FFFF.
- Flush mid-divide:
  - Prior result hi=2, lo=14; start DIV, `flush` at N+10.
  - Expect IDLE at N+11, no `done`, hi/lo still 2/14.
  - New MULTU started at N+11 → `done` at N+13.
- Reset asserted during DIV at N+5 → immediately IDLE, hi=lo=0, `done`=0. After release, DIVU 9/4 gives lo=2, hi=1 at N'+33.
